exu_muldiv: RTL and testbench

Execution unit for RV32M that consumes the MULDIV request group produced by the dispatch stage: operands, one-hot op flags and rd address. It computes products in a registered single-cycle 33x33 signed multiplier. It computes quotients and remainders with a 32-iteration radix-2 restoring divider. It holds the result until writeback accepts it, and tells the pipeline to stall via busy_o.

---
 rtl/exu_muldiv.sv | 264 ++++++++++++++++++++++++++
 tb/tb_exu_muldiv.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv.sv
// RV32M multiply/divide execution unit.
// Products come from a registered 33x33 signed multiplier; quotients and
// remainders come from a 32-step radix-2 restoring divider. The result is
// held until writeback takes it; busy_o stalls dispatch meanwhile.
`timescale 1ns/1ps

module exu_muldiv #(
    parameter int XLEN         = 32,
    parameter bit DIV_SHORTCUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_muldiv_i,
    input  logic [XLEN-1:0] muldiv_op1_i,
    input  logic [XLEN-1:0] muldiv_op2_i,
    input  logic            muldiv_op_mul_i,
    input  logic            muldiv_op_mulh_i,
    input  logic            muldiv_op_mulhsu_i,
    input  logic            muldiv_op_mulhu_i,
    input  logic            muldiv_op_div_i,
    input  logic            muldiv_op_divu_i,
    input  logic            muldiv_op_rem_i,
    input  logic            muldiv_op_remu_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    input  logic            wb_ready_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // State and datapath registers
    logic [2:0]      state_q,  state_d;
    logic [4:0]      cnt_q,    cnt_d;
    logic            init_q,   init_d;    // first DIV cycle: operand prep / shortcut
    logic [XLEN-1:0] op1_q,    op1_d;
    logic [XLEN-1:0] op2_q,    op2_d;
    logic [4:0]      rd_q,     rd_d;
    logic            mul_lo_q, mul_lo_d;  // MUL returns low word
    logic            sx1_q,    sx1_d;     // sign-extend op1 for multiply
    logic            sx2_q,    sx2_d;     // sign-extend op2 for multiply
    logic            sdiv_q,   sdiv_d;    // signed divide/remainder
    logic            rsel_q,   rsel_d;    // return remainder instead of quotient
    logic [63:0]     prod_q,   prod_d;
    logic [31:0]     rem_q,    rem_d;
    logic [31:0]     quot_q,   quot_d;    // dividend shifts out, quotient shifts in
    logic [31:0]     dvsr_q,   dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q,  valid_d;

    // Request decode
    logic mul_req_s;
    logic div_req_s;

    // Multiplier datapath
    logic signed [32:0] mul_a_s;
    logic signed [32:0] mul_b_s;
    logic signed [63:0] mul_a64_s;
    logic signed [63:0] mul_b64_s;
    logic signed [63:0] prod_s;
    logic [31:0]        mul_res_s;

    // Divider datapath
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        special_s;
    logic [31:0] special_res_s;
    logic [31:0] op1_mag_s;
    logic [31:0] op2_mag_s;
    logic [32:0] shift_s;
    logic [32:0] diff_s;
    logic        neg_q_s;
    logic        neg_r_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    assign mul_req_s = muldiv_op_mul_i | muldiv_op_mulh_i | muldiv_op_mulhsu_i | muldiv_op_mulhu_i;
    assign div_req_s = muldiv_op_div_i | muldiv_op_divu_i | muldiv_op_rem_i | muldiv_op_remu_i;

    // Operands extended to 33 bits; the low 64 bits of the product are all any op needs.
    assign mul_a_s   = {sx1_q & op1_q[31], op1_q};
    assign mul_b_s   = {sx2_q & op2_q[31], op2_q};
    assign mul_a64_s = {{31{mul_a_s[32]}}, mul_a_s};
    assign mul_b64_s = {{31{mul_b_s[32]}}, mul_b_s};
    assign prod_s    = mul_a64_s * mul_b64_s;
    assign mul_res_s = mul_lo_q ? prod_q[31:0] : prod_q[63:32];

    assign div_zero_s    = (op2_q == 32'd0);
    assign div_ovf_s     = sdiv_q & (op1_q == 32'h8000_0000) & (op2_q == 32'hFFFF_FFFF);
    assign special_s     = div_zero_s | div_ovf_s;
    assign special_res_s = div_zero_s ? (rsel_q ? op1_q : 32'hFFFF_FFFF)
                                      : (rsel_q ? 32'd0 : 32'h8000_0000);

    assign op1_mag_s = (sdiv_q & op1_q[31]) ? (32'd0 - op1_q) : op1_q;
    assign op2_mag_s = (sdiv_q & op2_q[31]) ? (32'd0 - op2_q) : op2_q;

    // Trial subtraction: bit 32 of the difference is the borrow/sign.
    assign shift_s = {rem_q, quot_q[31]};
    assign diff_s  = shift_s - {1'b0, dvsr_q};

    // A zero divisor must keep the all-ones quotient, so it never negates.
    assign neg_q_s    = sdiv_q & (op1_q[31] ^ op2_q[31]) & ~div_zero_s;
    assign neg_r_s    = sdiv_q & op1_q[31];
    assign quot_fix_s = neg_q_s ? (32'd0 - quot_q) : quot_q;
    assign rem_fix_s  = neg_r_s ? (32'd0 - rem_q) : rem_q;

    // Next-state and datapath update for every FSM state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        init_d   = init_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rd_d     = rd_q;
        mul_lo_d = mul_lo_q;
        sx1_d    = sx1_q;
        sx2_d    = sx2_q;
        sdiv_d   = sdiv_q;
        rsel_d   = rsel_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        valid_d  = valid_q;

        if (flush_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_muldiv_i && !flush_i && (mul_req_s || div_req_s)) begin
                        op1_d    = muldiv_op1_i;
                        op2_d    = muldiv_op2_i;
                        rd_d     = rd_addr_i;
                        mul_lo_d = muldiv_op_mul_i;
                        sx1_d    = muldiv_op_mul_i | muldiv_op_mulh_i | muldiv_op_mulhsu_i;
                        sx2_d    = muldiv_op_mul_i | muldiv_op_mulh_i;
                        sdiv_d   = muldiv_op_div_i | muldiv_op_rem_i;
                        rsel_d   = muldiv_op_rem_i | muldiv_op_remu_i;
                        cnt_d    = 5'd0;
                        init_d   = 1'b1;
                        state_d  = mul_req_s ? S_MUL : S_DIV;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (cnt_q == 5'd0) begin
                        prod_d = prod_s;
                        cnt_d  = 5'd1;
                    end else begin
                        result_d = mul_res_s;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DIV: begin
                    if (init_q) begin
                        init_d = 1'b0;
                        if (DIV_SHORTCUT && special_s) begin
                            result_d = special_res_s;
                            valid_d  = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            quot_d = op1_mag_s;
                            dvsr_d = op2_mag_s;
                            rem_d  = 32'd0;
                            cnt_d  = 5'd0;
                        end
                    end else begin
                        if (!diff_s[32]) begin
                            rem_d  = diff_s[31:0];
                            quot_d = {quot_q[30:0], 1'b1};
                        end else begin
                            rem_d  = shift_s[31:0];
                            quot_d = {quot_q[30:0], 1'b0};
                        end
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_d = S_FIX;
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                end
                S_FIX: begin
                    result_d = rsel_q ? rem_fix_s : quot_fix_s;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (wb_ready_i) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            init_q   <= 1'b0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            rd_q     <= 5'd0;
            mul_lo_q <= 1'b0;
            sx1_q    <= 1'b0;
            sx2_q    <= 1'b0;
            sdiv_q   <= 1'b0;
            rsel_q   <= 1'b0;
            prod_q   <= 64'd0;
            rem_q    <= 32'd0;
            quot_q   <= 32'd0;
            dvsr_q   <= 32'd0;
            result_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rd_q     <= rd_d;
            mul_lo_q <= mul_lo_d;
            sx1_q    <= sx1_d;
            sx2_q    <= sx2_d;
            sdiv_q   <= sdiv_d;
            rsel_q   <= rsel_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o        = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign rd_addr_o      = valid_q ? rd_q : 5'd0;

endmodule

// File: tb/tb_exu_muldiv.sv
// Scoreboard bench for exu_muldiv: one instance with the divide shortcut
// enabled (a_*) and one with it disabled (b_*), driven by the same vectors.
`timescale 1ns/1ps

module tb_exu_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic [7:0]  ops = 8'd0;   // mul,mulh,mulhsu,mulhu,div,divu,rem,remu
    logic [4:0]  rd  = 5'd0;
    logic        flush = 1'b0;
    logic        wb_ready = 1'b1;

    logic        a_ready, a_busy, a_valid, b_ready, b_busy, b_valid;
    logic [31:0] a_res, b_res;
    logic [4:0]  a_rd, b_rd;

    localparam logic [7:0] OP_MUL = 8'h01, OP_MULH = 8'h02, OP_MULHSU = 8'h04, OP_MULHU = 8'h08;
    localparam logic [7:0] OP_DIV = 8'h10, OP_DIVU = 8'h20, OP_REM = 8'h40, OP_REMU = 8'h80;

    always #5 clk = ~clk;

    exu_muldiv #(.XLEN(32), .DIV_SHORTCUT(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_muldiv_i(req),
        .muldiv_op1_i(op1), .muldiv_op2_i(op2),
        .muldiv_op_mul_i(ops[0]), .muldiv_op_mulh_i(ops[1]),
        .muldiv_op_mulhsu_i(ops[2]), .muldiv_op_mulhu_i(ops[3]),
        .muldiv_op_div_i(ops[4]), .muldiv_op_divu_i(ops[5]),
        .muldiv_op_rem_i(ops[6]), .muldiv_op_remu_i(ops[7]),
        .rd_addr_i(rd), .flush_i(flush), .wb_ready_i(wb_ready),
        .ready_o(a_ready), .busy_o(a_busy), .result_valid_o(a_valid),
        .result_o(a_res), .rd_addr_o(a_rd));

    exu_muldiv #(.XLEN(32), .DIV_SHORTCUT(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_muldiv_i(req),
        .muldiv_op1_i(op1), .muldiv_op2_i(op2),
        .muldiv_op_mul_i(ops[0]), .muldiv_op_mulh_i(ops[1]),
        .muldiv_op_mulhsu_i(ops[2]), .muldiv_op_mulhu_i(ops[3]),
        .muldiv_op_div_i(ops[4]), .muldiv_op_divu_i(ops[5]),
        .muldiv_op_rem_i(ops[6]), .muldiv_op_remu_i(ops[7]),
        .rd_addr_i(rd), .flush_i(flush), .wb_ready_i(wb_ready),
        .ready_o(b_ready), .busy_o(b_busy), .result_valid_o(b_valid),
        .result_o(b_res), .rd_addr_o(b_rd));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   seen[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare one DUT's output against the head of its expectation queue.
    task automatic mon(input int d, input logic v, input logic [31:0] r, input logic [4:0] a,
                       input logic rdy);
        exp_t  e;
        int    sz;
        string p;
        p  = (d == 0) ? "a" : "b";
        sz = (d == 0) ? qa.size() : qb.size();
        if (!v) begin
            seen[d] = 0;
        end else if (sz == 0) begin
            chk({p, "_unexpected_valid"}, {31'd0, v}, 32'd0);
        end else begin
            e = (d == 0) ? qa[0] : qb[0];
            if (seen[d] == 0) chk({p, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
            chk({p, "_result"}, r, e.res);
            chk({p, "_rd"}, {27'd0, a}, {27'd0, e.rd});
            seen[d] = 1;
            if (rdy) begin
                if (d == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
                seen[d] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_valid, a_res, a_rd, wb_ready);
        mon(1, b_valid, b_res, b_rd, wb_ready);
    end

    // Issue one request once both units are idle; queue its expectation if wanted.
    task automatic issue(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input logic [31:0] exp, input int la,
                         input int lb, input bit want);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!(a_ready && b_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, n < 300}, 32'd1);
        req = 1'b1; op1 = x; op2 = y; ops = op; rd = r;
        if (want) begin
            e.res = exp; e.rd = r; e.acc = cyc + 1;
            e.lat = la; qa.push_back(e);
            e.lat = lb; qb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0; ops = 8'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        int n;
        seen[0] = 0;
        seen[1] = 0;
        #1;
        chk("rst_ready",  {30'd0, a_ready, b_ready}, 32'd3);
        chk("rst_busy",   {30'd0, a_busy,  b_busy},  32'd0);
        chk("rst_valid",  {30'd0, a_valid, b_valid}, 32'd0);
        chk("rst_result", a_res | b_res, 32'd0);
        chk("rst_rd",     {27'd0, a_rd | b_rd}, 32'd0);
        #11 rst = 1'b1;

        // Multiply family
        issue(OP_MUL,    32'hFFFF_FFFF, 32'd2, 5'd1, 32'hFFFF_FFFE, 2, 2, 1'b1);
        issue(OP_MULH,   32'hFFFF_FFFF, 32'd2, 5'd2, 32'hFFFF_FFFF, 2, 2, 1'b1);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'd2, 5'd3, 32'h0000_0001, 2, 2, 1'b1);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 2, 2, 1'b1);
        // Divide family
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34, 34, 1'b1);
        issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34, 34, 1'b1);
        issue(OP_DIVU, 32'd100,       32'd7, 5'd7, 32'd14,        34, 34, 1'b1);
        issue(OP_REMU, 32'd100,       32'd7, 5'd8, 32'd2,         34, 34, 1'b1);
        // Special cases: shortcut on a, iterative on b
        issue(OP_DIVU, 32'd7,         32'd0,         5'd10, 32'hFFFF_FFFF, 1, 34, 1'b1);
        issue(OP_REMU, 32'd7,         32'd0,         5'd11, 32'd7,         1, 34, 1'b1);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 34, 1'b1);
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1, 34, 1'b1);
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFFF, 1, 34, 1'b1);
        issue(OP_REM,  32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFF9, 1, 34, 1'b1);
        drain();

        // Back-pressure: result held for 5 cycles, stray request ignored
        wb_ready = 1'b0;
        issue(OP_MUL, 32'd5, 32'd6, 5'd9, 32'd30, 2, 2, 1'b1);
        n = 0;
        while (!a_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_busy", {30'd0, a_busy, b_busy}, 32'd3);
            if (i == 1) begin
                req = 1'b1; op1 = 32'd7; op2 = 32'd7; ops = OP_MUL; rd = 5'd20;
            end else begin
                req = 1'b0; ops = 8'd0;
            end
            @(negedge clk);
        end
        req = 1'b0; ops = 8'd0;
        @(posedge clk);
        #1 wb_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_ready_after", {30'd0, a_ready, b_ready}, 32'd3);
        drain();

        // Flush at divide iteration 10
        issue(OP_DIV, 32'd1000, 32'd3, 5'd16, 32'd0, 0, 0, 1'b0);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", {30'd0, a_ready, b_ready}, 32'd3);
        chk("flush_valid", {30'd0, a_valid, b_valid}, 32'd0);
        issue(OP_MUL, 32'd3, 32'd4, 5'd17, 32'd12, 2, 2, 1'b1);
        drain();

        // Asynchronous reset mid-divide
        issue(OP_DIVU, 32'd50, 32'd5, 5'd18, 32'd0, 0, 0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", {30'd0, a_ready, b_ready}, 32'd3);
        chk("arst_valid", {30'd0, a_valid, b_valid}, 32'd0);
        chk("arst_busy",  {30'd0, a_busy,  b_busy},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(OP_DIVU, 32'd9, 32'd3, 5'd19, 32'd3, 34, 34, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
